// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults, selector width and distribution-mode encoding for demux_sched.
package demux_pkg;
    localparam int N_DEF = 4;
    localparam int D_DEF = 16;
    localparam int SELW = $clog2(N_DEF);
    typedef enum logic {MODE_ADDR = 1'b0, MODE_RR = 1'b1} rr_mode_e;
endpackage

// File: rtl/demux_np.sv
// demux_np: one-hot data steering of a single word onto N outputs, unselected outputs zero.
module demux_np #(
    parameter int N = 4,
    parameter int D = 16
) (
    input  logic [D-1:0] i_data,
    input  logic [N-1:0] i_sel,
    output logic [D-1:0] o_data [N]
);
    always_comb begin
        for (int k = 0; k < N; k++) o_data[k] = i_sel[k] ? i_data : '0;
    end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: first free slot at or after the pointer, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    i_free,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_idx,
    output logic            o_found
);
    always_comb begin
        o_idx = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_free[i_ptr + SELW'(i)]) begin
                o_idx = i_ptr + SELW'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_sched.sv
// demux_sched: single-word-per-channel demultiplexer with addressed or round-robin slot scheduling.
module demux_sched
    import demux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [D-1:0]         i_data,
    input  logic [$clog2(N)-1:0] i_dest,
    input  logic                 i_rr_mode,
    input  logic                 i_flush,
    output logic                 o_ready,
    output logic [N-1:0]         o_valid,
    output logic [D-1:0]         o_demux [N],
    input  logic [N-1:0]         i_ready,
    output logic [15:0]          o_count
);
    localparam int SW = $clog2(N);
    logic [N-1:0]    valid_q, valid_d, drain, free, sel;
    logic [D-1:0]    data_q [N];
    logic [D-1:0]    data_d [N];
    logic [D-1:0]    steer [N];
    logic [SW-1:0]   ptr_q, ptr_d, pick_idx, target;
    logic [15:0]     count_q, count_d;
    logic            pick_found, rr, accept;
    rr_pick #(.N(N), .SELW(SW)) u_pick (
        .i_free(free), .i_ptr(ptr_q), .o_idx(pick_idx), .o_found(pick_found)
    );
    demux_np #(.N(N), .D(D)) u_steer (.i_data(i_data), .i_sel(sel), .o_data(steer));
    always_comb begin
        rr = rr_mode_e'(i_rr_mode) == MODE_RR;
        drain = valid_q & i_ready;
        free = ~valid_q | drain;
        target = rr ? pick_idx : i_dest;
        o_ready = (rr ? pick_found : free[i_dest]) & ~i_flush & ~i_rst;
        accept = i_valid & o_ready;
        sel = accept ? N'(1) << target : '0;
        valid_d = i_flush ? '0 : (valid_q & ~drain) | sel;
        for (int k = 0; k < N; k++) data_d[k] = sel[k] ? steer[k] : data_q[k];
        ptr_d = (accept && rr) ? target + SW'(1) : ptr_q;
        count_d = count_q + 16'(accept);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            ptr_q <= '0;
            count_q <= '0;
            for (int k = 0; k < N; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q <= ptr_d;
            count_q <= count_d;
            data_q <= data_d;
        end
    end
    assign o_valid = valid_q;
    assign o_demux = data_q;
    assign o_count = count_q;
endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed-vector self-checking bench for demux_sched.
module tb_demux_sched;
    logic        clk = 1'b0;
    logic        rst, valid, rr_mode, flush, ready_o;
    logic [15:0] data, count;
    logic [1:0]  dest;
    logic [3:0]  valid_o, ready_i;
    logic [15:0] demux [4];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    demux_sched dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_dest(dest),
        .i_rr_mode(rr_mode), .i_flush(flush), .o_ready(ready_o), .o_valid(valid_o),
        .o_demux(demux), .i_ready(ready_i), .o_count(count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1; valid = 1'b1; rr_mode = 1'b0; flush = 1'b0;
        data = 16'h0; dest = 2'd0; ready_i = 4'b0;
        #1;
        check("rst_ready_low", 32'(ready_o), 32'd0);
        step(); step();
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(ready_o), 32'd0);
        rst = 1'b0; #1;
        check("post_rst_ready", 32'(ready_o), 32'd1);
        valid = 1'b0;
        valid = 1'b1; dest = 2'd2; data = 16'hA5A5;
        step();
        valid = 1'b0; #1;
        check("addr_valid", 32'(valid_o), 32'h4);
        check("addr_data", 32'(demux[2]), 32'hA5A5);
        check("addr_count", 32'(count), 32'd1);
        valid = 1'b1; data = 16'h1234; #1;
        check("addr_full_blocks", 32'(ready_o), 32'd0);
        step();
        check("addr_hold_valid", 32'(valid_o), 32'h4);
        check("addr_hold_data", 32'(demux[2]), 32'hA5A5);
        ready_i = 4'b0100; #1;
        check("addr_drain_frees", 32'(ready_o), 32'd1);
        step();
        valid = 1'b0; ready_i = 4'b0; #1;
        check("swap_valid", 32'(valid_o), 32'h4);
        check("swap_data", 32'(demux[2]), 32'h1234);
        check("swap_count", 32'(count), 32'd2);
        ready_i = 4'b0100;
        step();
        ready_i = 4'b0; #1;
        check("drain_empty", 32'(valid_o), 32'h0);
        ready_i = 4'b0010; dest = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            valid = 1'b1; data = 16'(i); #1;
            check($sformatf("tput_ready%0d", i), 32'(ready_o), 32'd1);
            step();
            check($sformatf("tput_data%0d", i), 32'(demux[1]), 32'(i));
            check($sformatf("tput_valid%0d", i), 32'(valid_o), 32'h2);
        end
        valid = 1'b0;
        step();
        check("tput_empty", 32'(valid_o), 32'h0);
        check("tput_count", 32'(count), 32'd10);
        ready_i = 4'b0; rr_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; data = 16'h00B0 + 16'(k);
            step();
            check($sformatf("rr_valid%0d", k), 32'(valid_o), 32'((1 << (k + 1)) - 1));
            check($sformatf("rr_data%0d", k), 32'(demux[k]), 32'h00B0 + 32'(k));
        end
        data = 16'h00B4; #1;
        check("rr_full_ready", 32'(ready_o), 32'd0);
        check("rr_ptr_wrap", 32'(dut.ptr_q), 32'd0);
        ready_i = 4'b0010; #1;
        check("rr_drain_ready", 32'(ready_o), 32'd1);
        step();
        valid = 1'b0; ready_i = 4'b0; #1;
        check("rr5_valid", 32'(valid_o), 32'hF);
        check("rr5_data", 32'(demux[1]), 32'h00B4);
        check("rr5_ptr", 32'(dut.ptr_q), 32'd2);
        check("rr5_count", 32'(count), 32'd15);
        flush = 1'b1; valid = 1'b1; ready_i = 4'b0001; #1;
        check("flush_ready", 32'(ready_o), 32'd0);
        step();
        flush = 1'b0; valid = 1'b0; ready_i = 4'b0; #1;
        check("flush_valid", 32'(valid_o), 32'h0);
        check("flush_count", 32'(count), 32'd15);
        check("flush_ptr", 32'(dut.ptr_q), 32'd2);
        check("flush_hold_data", 32'(demux[0]), 32'h00B0);
        valid = 1'b1; data = 16'h00C0;
        step();
        check("rr_from_ptr_valid", 32'(valid_o), 32'h4);
        check("rr_from_ptr_ptr", 32'(dut.ptr_q), 32'd3);
        rr_mode = 1'b0; dest = 2'd0; data = 16'h00C1;
        step();
        check("addr_keeps_ptr", 32'(dut.ptr_q), 32'd3);
        dest = 2'd1; data = 16'h00C2;
        step();
        check("pre_rst_valid", 32'(valid_o), 32'h7);
        check("pre_rst_count", 32'(count), 32'd18);
        rst = 1'b1; dest = 2'd3; #1;
        check("midrst_ready", 32'(ready_o), 32'd0);
        step();
        rst = 1'b0; valid = 1'b0; #1;
        check("midrst_valid", 32'(valid_o), 32'h0);
        check("midrst_ptr", 32'(dut.ptr_q), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_data", 32'(demux[2]), 32'd0);
        rr_mode = 1'b1; ready_i = 4'hF; valid = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        check("wrap_pre", 32'(count), 32'hFFFF);
        step();
        valid = 1'b0; #1;
        check("wrap_post", 32'(count), 32'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
